// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared types and helpers for the AES step blocks.
//   aes_byte_t    : one state byte
//   aes_state_t   : 4x4 byte state indexed [row][col]
//   isr_state_e   : control states of the InvShiftRows step
//   pack_state    : aes_state_t -> 128-bit vector
//   unpack_state  : 128-bit vector -> aes_state_t
// Byte k of a 128-bit vector lives at bits [127-8k -: 8]; it maps to
// row k%4, column k/4 (column-major, as in FIPS-197).
// -----------------------------------------------------------------------------
package aes_pkg;

    typedef logic [7:0] aes_byte_t;
    typedef aes_byte_t aes_state_t [4][4];

    typedef enum logic [2:0] {
        IDLE,
        ROT1,
        ROT2,
        ROT3,
        DONE
    } isr_state_e;

    function automatic logic [127:0] pack_state(input aes_state_t s);
        logic [127:0] v;
        v = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                v[7'(127 - 8 * (4 * c + r)) -: 8] = s[2'(r)][2'(c)];
            end
        end
        return v;
    endfunction

    function automatic void unpack_state(input logic [127:0] v, output aes_state_t s);
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                s[2'(r)][2'(c)] = v[7'(127 - 8 * (4 * c + r)) -: 8];
            end
        end
    endfunction

endpackage

// File: rtl/inv_row_rotate.sv
// -----------------------------------------------------------------------------
// inv_row_rotate
// Combinational helper: returns the state with one row rotated right by one
// byte position (new[c] = old[(c-1) mod 4]); all other rows pass through.
//   state_i : input state
//   row     : row to rotate (0..3)
//   state_o : state with the selected row rotated
// -----------------------------------------------------------------------------
module inv_row_rotate
    import aes_pkg::*;
(
    input  aes_state_t  state_i,
    input  logic [1:0]  row,
    output aes_state_t  state_o
);

    always_comb begin
        state_o = state_i;
        for (int c = 0; c < 4; c++) begin
            // 2-bit truncation of c+3 gives (c-1) mod 4
            state_o[row][2'(c)] = state_i[row][2'(c + 3)];
        end
    end

endmodule

// File: rtl/inv_shift_rows_step.sv
// -----------------------------------------------------------------------------
// inv_shift_rows_step
// AES InvShiftRows step: row r of the state is rotated right by r bytes,
// one single-byte rotation per cycle (row1 x1, row2 x2, row3 x3), so the
// result appears 6 cycles after the load edge.
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset, aborts any operation
//   start  : launch request, rising edge only (ignored while rotating)
//   in     : 128-bit state, captured on the accepted start edge
//   key    : round key, present for a uniform step interface, not used
//   finish : high while out holds a valid result
//   out    : transformed state
// -----------------------------------------------------------------------------
module inv_shift_rows_step
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] in,
    input  logic [127:0] key,
    output logic         finish,
    output logic [127:0] out
);

    isr_state_e   state, state_n;
    logic [1:0]   cnt, cnt_n;
    logic         start_q;
    logic [127:0] work, work_n;
    logic [127:0] out_n;
    logic         finish_n;
    logic [1:0]   sel;
    aes_state_t   work_st, rot_st;
    logic [127:0] rot_vec;
    logic         start_edge;
    logic         unused_key;

    assign unused_key = ^key;
    assign start_edge = start & ~start_q;

    always_comb unpack_state(work, work_st);

    inv_row_rotate u_rot (
        .state_i (work_st),
        .row     (sel),
        .state_o (rot_st)
    );

    assign rot_vec = pack_state(rot_st);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 2'd0;
            start_q <= 1'b0;
            work    <= '0;
            out     <= '0;
            finish  <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            start_q <= start;
            work    <= work_n;
            out     <= out_n;
            finish  <= finish_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        work_n   = work;
        out_n    = out;
        finish_n = finish;
        sel      = 2'd0;
        case (state)
            IDLE, DONE: begin
                if (start_edge) begin
                    work_n   = in;
                    finish_n = 1'b0;
                    cnt_n    = 2'd0;
                    state_n  = ROT1;
                end
            end
            ROT1: begin
                sel     = 2'd1;
                work_n  = rot_vec;
                cnt_n   = 2'd0;
                state_n = ROT2;
            end
            ROT2: begin
                sel    = 2'd2;
                work_n = rot_vec;
                if (cnt == 2'd1) begin
                    cnt_n   = 2'd0;
                    state_n = ROT3;
                end else begin
                    cnt_n = cnt + 2'd1;
                end
            end
            ROT3: begin
                sel    = 2'd3;
                work_n = rot_vec;
                if (cnt == 2'd2) begin
                    // last rotation lands directly in the output register
                    out_n    = rot_vec;
                    finish_n = 1'b1;
                    cnt_n    = 2'd0;
                    state_n  = DONE;
                end else begin
                    cnt_n = cnt + 2'd1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_inv_shift_rows_step.sv
// -----------------------------------------------------------------------------
// tb_inv_shift_rows_step
// Scoreboard bench for inv_shift_rows_step: expected states are queued when
// an operation is launched and compared when finish rises.
// -----------------------------------------------------------------------------
module tb_inv_shift_rows_step;

    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] in_d;
    logic [127:0] key_d;
    logic         finish;
    logic [127:0] out_d;

    int           n_vec = 0;
    int           n_miscmp = 0;
    int           cyc = 0;
    int           load_cyc = 0;
    logic [127:0] sb[$];

    inv_shift_rows_step dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .in     (in_d),
        .key    (key_d),
        .finish (finish),
        .out    (out_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // out[r][c] = in[r][(c-r) mod 4]
    function automatic logic [127:0] inv_sr_model(input logic [127:0] v);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127 - 8 * (4 * c + r) -: 8] = v[127 - 8 * (4 * ((c - r + 4) % 4) + r) -: 8];
        return o;
    endfunction

    // forward ShiftRows: out[r][c] = in[r][(c+r) mod 4]
    function automatic logic [127:0] sr_model(input logic [127:0] v);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127 - 8 * (4 * c + r) -: 8] = v[127 - 8 * (4 * ((c + r) % 4) + r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // drive a start edge; the load edge is the next posedge
    task automatic launch(input logic [127:0] v, input logic [127:0] k,
                          input logic [127:0] e, input bit push);
        in_d  = v;
        key_d = k;
        start = 1'b1;
        if (push) sb.push_back(e);
        step();
        load_cyc = cyc;
    endtask

    task automatic wait_done(input string tag);
        logic [127:0] e;
        int n;
        n = 0;
        while (finish !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        if (finish !== 1'b1) begin
            chk({tag, "_timeout"}, {127'd0, finish}, 128'd1);
            if (sb.size() > 0) void'(sb.pop_front());
        end else begin
            chk({tag, "_lat"}, 128'(cyc - load_cyc), 128'd6);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk({tag, "_out"}, out_d, e);
            end else begin
                chk({tag, "_unexpected"}, 128'd1, 128'd0);
            end
        end
    endtask

    initial begin
        logic [127:0] v, e, k;
        int seen;

        rst   = 1'b1;
        start = 1'b0;
        in_d  = '0;
        key_d = '0;
        step();
        step();
        chk("rst_finish", {127'd0, finish}, 128'd0);
        chk("rst_out", out_d, 128'd0);
        rst = 1'b0;
        step();

        // 1: two-cycle start pulse
        launch(128'h6b407e2a2e3d17e2e993be9673c19f11, '0,
               128'h6bc1bee22e409f96e93d7e117393172a, 1'b1);
        step();
        start = 1'b0;
        wait_done("t1");
        step();

        // 2: key has no influence
        launch(128'hae036f511eb78e579eaf8a9c452dacac, 128'h2b7e151628aed2a6abf7158809cf4f3c,
               128'hae2d8a571e03ac9c9eb76fac45af8e51, 1'b1);
        start = 1'b0;
        wait_done("t2a");
        step();
        launch(128'hae036f511eb78e579eaf8a9c452dacac, rand128(),
               128'hae2d8a571e03ac9c9eb76fac45af8e51, 1'b1);
        start = 1'b0;
        wait_done("t2b");
        step();

        // 3: byte-index pattern, then ShiftRows round trips and random vectors
        launch(128'h000102030405060708090a0b0c0d0e0f, rand128(),
               128'h000d0a0704010e0b0805020f0c090603, 1'b1);
        start = 1'b0;
        wait_done("t3");
        step();
        for (int i = 0; i < 3; i++) begin
            v = rand128();
            launch(sr_model(v), rand128(), v, 1'b1);
            start = 1'b0;
            in_d  = rand128();
            wait_done("t3_rt");
            step();
        end
        for (int i = 0; i < 2; i++) begin
            v = rand128();
            launch(v, rand128(), inv_sr_model(v), 1'b1);
            start = 1'b0;
            wait_done("t3_rnd");
            step();
        end

        // 4: reset in the middle of an operation
        launch(rand128(), '0, '0, 1'b0);
        start = 1'b0;
        rst   = 1'b1;
        step();
        rst = 1'b0;
        chk("t4_finish", {127'd0, finish}, 128'd0);
        chk("t4_out", out_d, 128'd0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (finish === 1'b1) seen++;
        end
        chk("t4_no_result", 128'(seen), 128'd0);
        v = rand128();
        launch(v, '0, inv_sr_model(v), 1'b1);
        start = 1'b0;
        wait_done("t4_fresh");
        step();

        // 5: start held high for 20 cycles -> one operation, stable output
        v = rand128();
        e = inv_sr_model(v);
        launch(v, '0, e, 1'b1);
        wait_done("t5");
        while (cyc - load_cyc < 19) begin
            in_d = rand128();
            step();
            chk("t5_hold_fin", {127'd0, finish}, 128'd1);
            chk("t5_hold_out", out_d, e);
        end
        start = 1'b0;
        step();

        // 5b: start edge during ROT3 is ignored
        v = rand128();
        e = inv_sr_model(v);
        launch(v, '0, e, 1'b1);
        start = 1'b0;
        while (cyc - load_cyc < 4) step();
        in_d  = rand128();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done("t5b");
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5b_fin", {127'd0, finish}, 128'd1);
            chk("t5b_out", out_d, e);
        end

        // 6: new start while DONE
        v = rand128();
        k = rand128();
        launch(v, k, inv_sr_model(v), 1'b1);
        chk("t6_drop", {127'd0, finish}, 128'd0);
        start = 1'b0;
        wait_done("t6");
        step();

        chk("sb_empty", 128'(sb.size()), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
